regfile_mp: RTL and testbench

//  Parametrised multi-port register file; successor to the single-port regfile used for energy characterisation.

---
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-byte write masks, registered
// reads with a valid flag, optional write-first bypass, an optional hardwired
// zero entry 0, and a flag that reports overlapping writes.
module regfile_mp #(
    parameter int N        = 32,
    parameter int WIDTH    = 32,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = (N > 1) ? $clog2(N) : 1,
    localparam int NB      = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NR-1:0]         R_en,
    input  logic [NR*AW-1:0]      R_addr,
    output logic [NR*WIDTH-1:0]   R_data,
    output logic [NR-1:0]         R_valid,
    input  logic [NW-1:0]         W_en,
    input  logic [NW*AW-1:0]      W_addr,
    input  logic [NW*NB-1:0]      W_mask,
    input  logic [NW*WIDTH-1:0]   W_data,
    output logic                  W_conflict
);

    // Entry count widened by one bit so that N itself is representable.
    localparam logic [AW:0] N_L = (AW+1)'(N);

    logic [WIDTH-1:0]    mem_q [N];
    logic [WIDTH-1:0]    mem_d [N];
    logic [NR*WIDTH-1:0] r_data_q;
    logic [NR*WIDTH-1:0] r_data_d;
    logic [NR-1:0]       r_valid_q;
    logic [NR-1:0]       r_valid_d;
    logic                w_conflict_q;
    logic                w_conflict_d;
    logic [NW-1:0]       w_ok_s;

    // An address is usable when it names a real entry and is not the hardwired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        logic zero_hit;
        in_range = ({1'b0, a} < N_L);
        zero_hit = (ZERO_REG != 0) && (a == {AW{1'b0}});
        return in_range && !zero_hit;
    endfunction

    // Qualify each write port: enabled and targeting a writable entry.
    always_comb begin
        w_ok_s = {NW{1'b0}};
        for (int j = 0; j < NW; j++) begin
            w_ok_s[j] = W_en[j] && addr_ok(W_addr[j*AW +: AW]);
        end
    end

    // Post-write image of the array: per byte lane, the highest-index hitting port wins.
    always_comb begin
        logic [7:0] lane_v;
        lane_v = 8'h00;
        for (int e = 0; e < N; e++) begin
            mem_d[e] = mem_q[e];
            for (int b = 0; b < NB; b++) begin
                lane_v = mem_q[e][b*8 +: 8];
                for (int j = 0; j < NW; j++) begin
                    lane_v = (w_ok_s[j] && (W_addr[j*AW +: AW] == AW'(e)) && W_mask[j*NB + b])
                             ? W_data[j*WIDTH + b*8 +: 8] : lane_v;
                end
                mem_d[e][b*8 +: 8] = lane_v;
            end
        end
    end

    // Read ports: pick the addressed word (post-write when bypassing), zero when unusable.
    always_comb begin
        logic [WIDTH-1:0] word_v;
        word_v    = {WIDTH{1'b0}};
        r_data_d  = r_data_q;
        r_valid_d = R_en;
        for (int i = 0; i < NR; i++) begin
            word_v = {WIDTH{1'b0}};
            for (int e = 0; e < N; e++) begin
                word_v = ((R_addr[i*AW +: AW] == AW'(e)) && addr_ok(R_addr[i*AW +: AW]))
                         ? ((BYPASS != 0) ? mem_d[e] : mem_q[e]) : word_v;
            end
            if (R_en[i]) begin
                r_data_d[i*WIDTH +: WIDTH] = word_v;
            end else begin
                r_data_d[i*WIDTH +: WIDTH] = r_data_q[i*WIDTH +: WIDTH];
            end
        end
    end

    // Conflict: two usable writes to the same entry that share at least one byte lane.
    always_comb begin
        w_conflict_d = 1'b0;
        for (int j = 0; j < NW; j++) begin
            for (int k = j + 1; k < NW; k++) begin
                w_conflict_d = w_conflict_d
                    | (w_ok_s[j] & w_ok_s[k]
                       & (W_addr[j*AW +: AW] == W_addr[k*AW +: AW])
                       & (|(W_mask[j*NB +: NB] & W_mask[k*NB +: NB])));
            end
        end
    end

    // State registers; synchronous reset discards every access in its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < N; e++) begin
                mem_q[e] <= {WIDTH{1'b0}};
            end
            r_data_q     <= {(NR*WIDTH){1'b0}};
            r_valid_q    <= {NR{1'b0}};
            w_conflict_q <= 1'b0;
        end else begin
            for (int e = 0; e < N; e++) begin
                mem_q[e] <= mem_d[e];
            end
            r_data_q     <= r_data_d;
            r_valid_q    <= r_valid_d;
            w_conflict_q <= w_conflict_d;
        end
    end

    assign R_data     = r_data_q;
    assign R_valid    = r_valid_q;
    assign W_conflict = w_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four instances (default, no bypass, N=20, zero entry)
// share one directed stimulus stream; a behavioural model per instance is
// compared every cycle, plus literal expectations at key points.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  R_en;
    logic [9:0]  R_addr;
    logic [1:0]  W_en;
    logic [9:0]  W_addr;
    logic [7:0]  W_mask;
    logic [63:0] W_data;

    logic [63:0] rdata  [4];
    logic [1:0]  rvalid [4];
    logic        cflt   [4];

    int cfg_n   [4] = '{32, 32, 20, 32};
    int cfg_byp [4] = '{1, 0, 1, 1};
    int cfg_zr  [4] = '{0, 0, 0, 1};

    logic [31:0] m_mem [4][32];
    logic [63:0] m_rd  [4];
    logic [1:0]  m_rv  [4];
    logic        m_cf  [4];

    int n_chk  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.N(32), .BYPASS(1), .ZERO_REG(0)) u_def (
        .clk(clk), .reset(reset), .R_en(R_en), .R_addr(R_addr), .R_data(rdata[0]),
        .R_valid(rvalid[0]), .W_en(W_en), .W_addr(W_addr), .W_mask(W_mask),
        .W_data(W_data), .W_conflict(cflt[0]));
    regfile_mp #(.N(32), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
        .clk(clk), .reset(reset), .R_en(R_en), .R_addr(R_addr), .R_data(rdata[1]),
        .R_valid(rvalid[1]), .W_en(W_en), .W_addr(W_addr), .W_mask(W_mask),
        .W_data(W_data), .W_conflict(cflt[1]));
    regfile_mp #(.N(20), .BYPASS(1), .ZERO_REG(0)) u_n20 (
        .clk(clk), .reset(reset), .R_en(R_en), .R_addr(R_addr), .R_data(rdata[2]),
        .R_valid(rvalid[2]), .W_en(W_en), .W_addr(W_addr), .W_mask(W_mask),
        .W_data(W_data), .W_conflict(cflt[2]));
    regfile_mp #(.N(32), .BYPASS(1), .ZERO_REG(1)) u_zero (
        .clk(clk), .reset(reset), .R_en(R_en), .R_addr(R_addr), .R_data(rdata[3]),
        .R_valid(rvalid[3]), .W_en(W_en), .W_addr(W_addr), .W_mask(W_mask),
        .W_data(W_data), .W_conflict(cflt[3]));

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Behavioural model: what each instance must hold and show after this edge.
    always @(posedge clk) begin : model
        logic [31:0] nxt [32];
        int a;
        int a2;
        for (int c = 0; c < 4; c++) begin
            if (reset) begin
                for (int e = 0; e < 32; e++) m_mem[c][e] = 32'h0;
                m_rd[c] = 64'h0;
                m_rv[c] = 2'b00;
                m_cf[c] = 1'b0;
            end else begin
                for (int e = 0; e < 32; e++) nxt[e] = m_mem[c][e];
                for (int j = 0; j < 2; j++) begin
                    a = int'(W_addr[j*5 +: 5]);
                    if (W_en[j] && a < cfg_n[c] && !(cfg_zr[c] != 0 && a == 0))
                        for (int b = 0; b < 4; b++)
                            if (W_mask[j*4 + b]) nxt[a][b*8 +: 8] = W_data[j*32 + b*8 +: 8];
                end
                a  = int'(W_addr[4:0]);
                a2 = int'(W_addr[9:5]);
                m_cf[c] = (W_en == 2'b11) && (a == a2) && (a < cfg_n[c])
                          && !(cfg_zr[c] != 0 && a == 0) && ((W_mask[3:0] & W_mask[7:4]) != 4'h0);
                for (int i = 0; i < 2; i++) begin
                    m_rv[c][i] = R_en[i];
                    if (R_en[i]) begin
                        a = int'(R_addr[i*5 +: 5]);
                        if (a >= cfg_n[c] || (cfg_zr[c] != 0 && a == 0)) m_rd[c][i*32 +: 32] = 32'h0;
                        else if (cfg_byp[c] != 0) m_rd[c][i*32 +: 32] = nxt[a];
                        else m_rd[c][i*32 +: 32] = m_mem[c][a];
                    end
                end
                for (int e = 0; e < 32; e++) m_mem[c][e] = nxt[e];
            end
        end
    end

    // Compare every instance against the model away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int c = 0; c < 4; c++) begin
                chk("r_data0", c, {32'h0, rdata[c][31:0]},  {32'h0, m_rd[c][31:0]});
                chk("r_data1", c, {32'h0, rdata[c][63:32]}, {32'h0, m_rd[c][63:32]});
                chk("r_valid", c, {62'h0, rvalid[c]},       {62'h0, m_rv[c]});
                chk("w_conflict", c, {63'h0, cflt[c]},      {63'h0, m_cf[c]});
            end
        end
    end

    task automatic wr(input int p, input logic [4:0] a, input logic [3:0] m, input logic [31:0] d);
        W_en[p] = 1'b1;
        W_addr[p*5 +: 5] = a;
        W_mask[p*4 +: 4] = m;
        W_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        R_en[p] = 1'b1;
        R_addr[p*5 +: 5] = a;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        R_en = 2'b00;
        W_en = 2'b00;
    endtask

    task automatic sweep();
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a));
            rd(1, 5'(31 - a));
            step();
        end
    endtask

    initial begin
        reset = 1'b1; R_en = 2'b00; R_addr = 10'h0; W_en = 2'b00;
        W_addr = 10'h0; W_mask = 8'h0; W_data = 64'h0;
        wr(0, 5'd3, 4'hF, 32'hCAFEF00D);
        step();
        checking = 1'b1;
        reset = 1'b0;

        // reset state visible through a read of both ends of the array
        rd(0, 5'd0); rd(1, 5'd31); step();
        chk("lit_reset_rdata", 0, rdata[0], 64'h0);
        chk("lit_reset_rvalid", 0, {62'h0, rvalid[0]}, {62'h0, 2'b11});
        chk("lit_reset_cflt", 0, {63'h0, cflt[0]}, 64'h0);

        // full-word write then read
        wr(0, 5'd5, 4'hF, 32'hA5A5A5A5); step();
        rd(0, 5'd5); step();
        chk("lit_read5", 0, {32'h0, rdata[0][31:0]}, {32'h0, 32'hA5A5A5A5});

        // overlapping masked writes to the same entry
        wr(0, 5'd7, 4'b0011, 32'h11112222);
        wr(1, 5'd7, 4'b0110, 32'h33334444); step();
        chk("lit_cflt_set", 0, {63'h0, cflt[0]}, 64'h1);
        chk("lit_model_e7", 0, {32'h0, m_mem[0][7]}, {32'h0, 32'h00334422});
        step();
        chk("lit_cflt_clr", 0, {63'h0, cflt[0]}, 64'h0);
        rd(0, 5'd7); step();
        chk("lit_read7", 0, {32'h0, rdata[0][31:0]}, {32'h0, 32'h00334422});

        // read during write, with and without bypass
        wr(0, 5'd9, 4'hF, 32'hDEADBEEF); step();
        wr(0, 5'd9, 4'b1000, 32'h12000000); rd(1, 5'd9); step();
        chk("lit_byp1", 0, {32'h0, rdata[0][63:32]}, {32'h0, 32'h12ADBEEF});
        chk("lit_byp0", 1, {32'h0, rdata[1][63:32]}, {32'h0, 32'hDEADBEEF});
        rd(1, 5'd9); step();
        chk("lit_byp0_next", 1, {32'h0, rdata[1][63:32]}, {32'h0, 32'h12ADBEEF});

        // idle: valid drops, data holds
        step();
        chk("lit_hold_valid", 0, {62'h0, rvalid[0]}, 64'h0);
        chk("lit_hold_data", 0, {32'h0, rdata[0][63:32]}, {32'h0, 32'h12ADBEEF});

        // out-of-range address on the N=20 instance
        wr(0, 5'd25, 4'hF, 32'hFFFFFFFF); rd(0, 5'd25); step();
        chk("lit_oor_data", 2, {32'h0, rdata[2][31:0]}, 64'h0);
        chk("lit_oor_valid", 2, {63'h0, rvalid[2][0]}, 64'h1);
        chk("lit_inrange_byp", 0, {32'h0, rdata[0][31:0]}, {32'h0, 32'hFFFFFFFF});
        wr(0, 5'd26, 4'hF, 32'h01010101); wr(1, 5'd26, 4'hF, 32'h02020202); step();
        chk("lit_oor_cflt", 2, {63'h0, cflt[2]}, 64'h0);
        chk("lit_inr_cflt", 0, {63'h0, cflt[0]}, 64'h1);

        // enabled writes with empty masks are neither writes nor conflicts
        wr(0, 5'd12, 4'h0, 32'h77777777); wr(1, 5'd12, 4'h0, 32'h88888888); step();
        chk("lit_nomask_cflt", 0, {63'h0, cflt[0]}, 64'h0);

        // two ports on one entry while it is read
        wr(0, 5'd14, 4'hF, 32'h11111111); wr(1, 5'd14, 4'b0101, 32'h22222222); rd(0, 5'd14); step();
        chk("lit_prio_byp", 0, {32'h0, rdata[0][31:0]}, {32'h0, 32'h11221122});
        chk("lit_prio_nobyp", 1, {32'h0, rdata[1][31:0]}, 64'h0);

        // hardwired zero entry
        wr(0, 5'd0, 4'hF, 32'h00000001); rd(1, 5'd0); step();
        chk("lit_zero_byp", 3, {32'h0, rdata[3][63:32]}, 64'h0);
        rd(0, 5'd0); step();
        chk("lit_zero_read", 3, {32'h0, rdata[3][31:0]}, 64'h0);
        chk("lit_e0_normal", 0, {32'h0, rdata[0][31:0]}, 64'h1);

        sweep();

        // reset with traffic in flight
        wr(0, 5'd4, 4'hF, 32'hAAAA5555); wr(1, 5'd5, 4'hF, 32'h5555AAAA);
        rd(0, 5'd5); rd(1, 5'd7); reset = 1'b1; step();
        reset = 1'b0;
        chk("lit_rst_rdata", 0, rdata[0], 64'h0);
        chk("lit_rst_rvalid", 0, {62'h0, rvalid[0]}, 64'h0);
        rd(0, 5'd7); step();
        chk("lit_rst_e7", 0, {32'h0, rdata[0][31:0]}, 64'h0);

        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
